// File: rtl/apa102_ws2812_pkg.sv
// rtl/apa102_ws2812_pkg.sv - shared constants, frame classification and state types for the APA102-to-WS2812 bridge
package apa102_ws2812_pkg;

    localparam int GRB_W       = 24;
    localparam int WORD_W      = 32;
    localparam int DEF_T0H_CYC = 4;
    localparam int DEF_T1H_CYC = 8;
    localparam int DEF_BIT_CYC = 13;

    localparam logic [WORD_W-1:0] FRAME_START = 32'h0000_0000;
    localparam logic [WORD_W-1:0] FRAME_END   = 32'hFFFF_FFFF;
    localparam logic [2:0]        LED_HDR     = 3'b111;

    typedef enum logic {
        RX_HUNT    = 1'b0,
        RX_ALIGNED = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        FR_START = 2'd0,
        FR_LED   = 2'd1,
        FR_END   = 2'd2,
        FR_BAD   = 2'd3
    } frame_kind_t;

    function automatic frame_kind_t frame_kind(input logic [WORD_W-1:0] w);
        if (w == FRAME_START)          return FR_START;
        else if (w == FRAME_END)       return FR_END;
        else if (w[31:29] == LED_HDR)  return FR_LED;
        else                           return FR_BAD;
    endfunction

    // APA102 carries {hdr,brightness,B,G,R}; WS2812 wants G,R,B on the wire
    function automatic logic [GRB_W-1:0] led_to_grb(input logic [WORD_W-1:0] w);
        return {w[15:8], w[7:0], w[23:16]};
    endfunction

endpackage

// File: rtl/apa102_ws2812_squidgeefish_if.sv
// rtl/apa102_ws2812_squidgeefish_if.sv - GRB pixel stream between holding register and WS2812 transmitter
interface apa102_ws2812_squidgeefish_if;
    import apa102_ws2812_pkg::*;

    logic [GRB_W-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/apa102_ws2812_squidgeefish_tx.sv
// rtl/apa102_ws2812_squidgeefish_tx.sv - WS2812 NRZ serialiser, one 24-bit GRB word per accepted beat
module ws2812_tx
    import apa102_ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    apa102_ws2812_squidgeefish_if.slave   s,
    output logic                          dout,
    output logic                          busy
);
    localparam int PW = $clog2(BIT_CYC);
    localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYC - 1);
    localparam logic [PW-1:0] T0H_P    = PW'(T0H_CYC);
    localparam logic [PW-1:0] T1H_P    = PW'(T1H_CYC);
    localparam logic [4:0]    LAST_BIT = 5'(GRB_W - 1);

    logic [PW-1:0]    phase;
    logic [4:0]       bit_cnt;
    logic [GRB_W-1:0] shreg;
    logic             last_cycle;

    assign last_cycle = busy && (phase == PH_LAST) && (bit_cnt == LAST_BIT);
    // Accepting during the final low cycle lets words run back to back with no gap
    assign s.tready   = !busy || last_cycle;
    assign dout       = busy && (phase < (shreg[GRB_W-1] ? T1H_P : T0H_P));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (s.tvalid && s.tready) begin
            shreg   <= s.tdata;
            phase   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (phase == PH_LAST) begin
                phase   <= '0;
                shreg   <= {shreg[GRB_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == LAST_BIT) busy <= 1'b0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/apa102_ws2812_squidgeefish.sv
// rtl/apa102_ws2812_squidgeefish.sv - APA102 SCK/SDA receiver bridged to a WS2812 one-wire transmitter
module apa102_ws2812_squidgeefish
    import apa102_ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in};

    logic [1:0] sck_sync;
    logic [1:0] sda_sync;
    logic       sck_prev;
    logic       sck_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            sda_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], ui_in[0]};
            sda_sync <= {sda_sync[0], ui_in[1]};
            sck_prev <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;

    // cnt counts consecutive zeros while hunting and word bits once aligned
    rx_state_t         state, state_n;
    logic [WORD_W-1:0] sr, sr_n;
    logic [4:0]        cnt, cnt_n;
    logic              push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_HUNT;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        push    = 1'b0;
        if (sck_rise) begin
            sr_n = {sr[WORD_W-2:0], sda_sync[1]};
            case (state)
                RX_HUNT: begin
                    if (sda_sync[1]) begin
                        cnt_n = '0;
                    end else if (cnt == 5'd31) begin
                        state_n = RX_ALIGNED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                RX_ALIGNED: begin
                    if (cnt == 5'd31) begin
                        cnt_n = '0;
                        case (frame_kind(sr_n))
                            FR_START: state_n = RX_ALIGNED;
                            FR_LED:   push    = 1'b1;
                            default:  state_n = RX_HUNT;
                        endcase
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                default: state_n = RX_HUNT;
            endcase
        end
    end

    apa102_ws2812_squidgeefish_if px();

    logic [GRB_W-1:0] hold_d;
    logic             hold_v;
    logic             overflow;
    logic             load;

    assign px.tdata  = hold_d;
    assign px.tvalid = hold_v;
    assign load      = px.tvalid && px.tready;

    // A push coinciding with a load refills holding without counting as overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_d   <= '0;
            hold_v   <= 1'b0;
            overflow <= 1'b0;
        end else if (push) begin
            hold_d <= led_to_grb(sr_n);
            hold_v <= 1'b1;
            if (hold_v && !load) overflow <= 1'b1;
        end else if (load) begin
            hold_v <= 1'b0;
        end
    end

    logic ws_dout;
    logic ws_busy;

    ws2812_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (px.slave),
        .dout  (ws_dout),
        .busy  (ws_busy)
    );

    assign uo_out  = {4'b0000, (state == RX_ALIGNED), overflow, ws_busy, ws_dout};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_apa102_ws2812_squidgeefish.sv
// tb/tb_apa102_ws2812_squidgeefish.sv - directed bench with word-level model and WS2812 waveform decoder
module tb_apa102_ws2812_squidgeefish;
    import apa102_ws2812_pkg::*;

    localparam int TX_CYC = GRB_W * DEF_BIT_CYC;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    always #50 clk = ~clk;

    apa102_ws2812_squidgeefish dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    apa102_ws2812_squidgeefish_if mon_if();
    assign mon_if.tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Word-level model of the spec rules
    bit          m_aligned = 0;
    int          zrun = 0;
    int          nb = 0;
    logic [31:0] wsr = '0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [23:0] m_hold = '0;
    bit          m_hold_v = 0;
    int          m_hold_t = 0;
    int          tx_free = 0;
    bit          exp_ovf = 0;

    task automatic model_push(input logic [23:0] g, input int t);
        if (m_hold_v && tx_free <= t) begin
            exp_q.push_back(m_hold);
            tx_free  = ((tx_free > m_hold_t + 1) ? tx_free : m_hold_t + 1) + TX_CYC;
            m_hold_v = 0;
        end
        if (!m_hold_v && tx_free <= t) begin
            exp_q.push_back(g);
            tx_free = t + 1 + TX_CYC;
        end else begin
            if (m_hold_v) exp_ovf = 1;
            m_hold   = g;
            m_hold_v = 1;
            m_hold_t = t;
        end
    endtask

    task automatic model_flush();
        if (m_hold_v) begin
            exp_q.push_back(m_hold);
            tx_free  = ((tx_free > m_hold_t + 1) ? tx_free : m_hold_t + 1) + TX_CYC;
            m_hold_v = 0;
        end
    endtask

    task automatic model_bit(input logic b);
        if (!m_aligned) begin
            if (b) zrun = 0;
            else begin
                zrun++;
                if (zrun == 32) begin
                    m_aligned = 1;
                    nb = 0;
                    zrun = 0;
                end
            end
        end else begin
            wsr = {wsr[30:0], b};
            nb++;
            if (nb == 32) begin
                nb = 0;
                if (wsr == 32'h0) begin
                end else if (wsr == 32'hFFFF_FFFF) begin
                    m_aligned = 0;
                end else if (wsr[31:29] == 3'b111) begin
                    model_push({wsr[15:8], wsr[7:0], wsr[23:16]}, cyc + 2);
                end else begin
                    m_aligned = 0;
                end
            end
        end
    endtask

    // SCK = clk/4, inputs change on falling clk edges
    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            @(negedge clk);
            ui_in[0] = 1'b0;
            ui_in[1] = w[i];
            @(negedge clk);
            @(negedge clk);
            ui_in[0] = 1'b1;
            @(negedge clk);
            model_bit(w[i]);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("aligned_flag", {31'd0, uo_out[3]}, {31'd0, m_aligned});
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!uo_out[1]) begin
                done = 1;
                break;
            end
        end
        check("tx_idle_timeout", {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
        check("pending_words", exp_q.size(), 32'd0);
        check("overflow_flag", {31'd0, uo_out[2]}, {31'd0, exp_ovf});
    endtask

    // Waveform decoder and per-cycle checker
    bit          prev_d = 0;
    int          hi_w = 0;
    int          last_rise = 0;
    int          nbits = 0;
    int          high_cycles = 0;
    logic [23:0] acc = '0;

    always @(negedge clk) begin
        checks++;
        if (uo_out[7:4] != 4'h0 || uio_out != 8'h00 || uio_oe != 8'h00) begin
            errors++;
            $display("FAIL static_pins got=%0h/%0h/%0h exp=0/0/0", uo_out[7:4], uio_out, uio_oe);
        end
        if (!rst_n) begin
            prev_d = 0;
            hi_w   = 0;
            nbits  = 0;
        end else begin
            if (uo_out[0]) high_cycles++;
            if (uo_out[0] && !uo_out[1]) begin
                checks++;
                errors++;
                $display("FAIL data_without_busy got=1 exp=0");
            end
            if (uo_out[0] && !prev_d) begin
                if (nbits % 24 != 0) check("bit_period", cyc - last_rise, DEF_BIT_CYC);
                last_rise = cyc;
                hi_w = 1;
            end else if (uo_out[0]) begin
                hi_w++;
            end else if (prev_d) begin
                checks++;
                if (hi_w != DEF_T0H_CYC && hi_w != DEF_T1H_CYC) begin
                    errors++;
                    $display("FAIL high_width got=%0d exp=%0d_or_%0d", hi_w, DEF_T0H_CYC, DEF_T1H_CYC);
                end
                acc = {acc[22:0], (hi_w == DEF_T1H_CYC)};
                nbits++;
                if (nbits % 24 == 0) begin
                    mon_if.tdata  = acc;
                    got_q.push_back(acc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ws_word got=%0h exp=none", acc);
                    end else begin
                        check("ws_word", {8'd0, acc}, {8'd0, exp_q.pop_front()});
                    end
                end
            end
            prev_d = uo_out[0];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        mon_if.tdata  = '0;
        mon_if.tvalid = 1'b0;

        repeat (5) @(negedge clk);
        check("reset_uo_out", {24'd0, uo_out}, 32'h00);
        check("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
        check("reset_uio_out", {24'd0, uio_out}, 32'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_uo_out", {24'd0, uo_out}, 32'h00);

        // No start frame: LED word must be ignored
        send_word(32'hFF0000FF);
        repeat (400) @(negedge clk);
        check("nostart_aligned", {31'd0, uo_out[3]}, 32'd0);
        check("nostart_high_cycles", high_cycles, 32'd0);
        check("nostart_words", got_q.size(), 32'd0);
        send_word(32'hFFFF_FFFF);

        // Single LED
        send_word(32'h0000_0000);
        check("aligned_after_start", {31'd0, uo_out[3]}, 32'd1);
        send_word(32'hFF0000FF);
        send_word(32'hFFFF_FFFF);
        check("aligned_after_end", {31'd0, uo_out[3]}, 32'd0);
        model_flush();
        wait_idle();
        check("one_led_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("one_led_grb", {8'd0, got_q.pop_front()}, 32'h00FF00);

        // Brightness ignored
        send_word(32'h0000_0000);
        send_word(32'hE1123456);
        send_word(32'hFF123456);
        send_word(32'hFFFF_FFFF);
        model_flush();
        wait_idle();
        check("bright_count", got_q.size(), 32'd2);
        if (got_q.size() > 0) check("bright_grb0", {8'd0, got_q.pop_front()}, 32'h345612);
        if (got_q.size() > 0) check("bright_grb1", {8'd0, got_q.pop_front()}, 32'h345612);
        check("no_overflow_yet", {31'd0, uo_out[2]}, 32'd0);

        // Malformed word drops alignment until a fresh start frame
        send_word(32'h0000_0000);
        send_word(32'h4000_0000);
        check("malformed_aligned", {31'd0, uo_out[3]}, 32'd0);
        send_word(32'hFF0000FF);
        repeat (400) @(negedge clk);
        check("malformed_words", got_q.size(), 32'd0);
        send_word(32'h0000_0000);
        send_word(32'hFFAABBCC);
        send_word(32'hFFFF_FFFF);
        model_flush();
        wait_idle();
        check("recover_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("recover_grb", {8'd0, got_q.pop_front()}, 32'hBBCCAA);

        // Overflow: third word overwrites the held second word
        send_word(32'h0000_0000);
        send_word(32'hFF112233);
        send_word(32'hFF445566);
        send_word(32'hFF778899);
        check("overflow_set", {31'd0, uo_out[2]}, 32'd1);
        send_word(32'hFFFF_FFFF);
        model_flush();
        wait_idle();
        check("overflow_count", got_q.size(), 32'd2);
        if (got_q.size() > 0) check("overflow_grb0", {8'd0, got_q.pop_front()}, 32'h223311);
        if (got_q.size() > 0) check("overflow_grb1", {8'd0, got_q.pop_front()}, 32'h889977);
        check("overflow_sticky", {31'd0, uo_out[2]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
